// File: rtl/alarm_pattern_gen.sv
// alarm_pattern_gen: programmable blink-pattern alarm sequencer with snooze,
// completion pulse and completed-cycle reporting.
module alarm_pattern_gen #(
  parameter int PERIOD       = 3,
  parameter int ON_STEPS     = 1,
  parameter int TICK_DIV     = 1,
  parameter int REPEAT       = 4,
  parameter int SNOOZE_STEPS = 6,
  parameter int CW           = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          snooze,
  output logic          light,
  output logic          active,
  output logic          snoozing,
  output logic          done,
  output logic [CW-1:0] cycle_count
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW  = $clog2(PERIOD);
  localparam int SNW = (SNOOZE_STEPS * TICK_DIV > 1) ? $clog2(SNOOZE_STEPS * TICK_DIV) : 1;

  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]  STEP_LAST = SW'(PERIOD - 1);
  localparam logic [SW-1:0]  ON_L      = SW'(ON_STEPS);
  localparam logic [SNW-1:0] SNZ_LOAD  = SNW'(SNOOZE_STEPS * TICK_DIV - 1);
  localparam logic [CW-1:0]  REP_L     = CW'(REPEAT);

  typedef enum logic [1:0] {IDLE, RUN, SNOOZE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [SW-1:0]   step_q, step_d;
  logic [SNW-1:0]  snz_q, snz_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_sat;
  logic            done_q, done_d;

  assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  // Next-state, counter and done-pulse decode; priority stop > snooze > start.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    step_d  = step_q;
    snz_d   = snz_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          tick_d  = '0;
          step_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (snooze) begin
          state_d = SNOOZE;
          snz_d   = SNZ_LOAD;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (step_q == STEP_LAST) begin
            step_d = '0;
            cnt_d  = cnt_sat;
            if ((REPEAT != 0) && (cnt_sat == REP_L)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            step_d = step_q + SW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      SNOOZE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (snooze) begin
          snz_d = SNZ_LOAD;
        end else if (snz_q == '0) begin
          state_d = RUN;
          tick_d  = '0;
          step_d  = '0;
        end else begin
          snz_d = snz_q - SNW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      step_q  <= '0;
      snz_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      snz_q   <= snz_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign light       = (state_q == RUN) && (step_q < ON_L);
  assign active      = (state_q != IDLE);
  assign snoozing    = (state_q == SNOOZE);
  assign done        = done_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_alarm_pattern_gen.sv
// Directed bench for alarm_pattern_gen: default instance plus a slow,
// endless-pattern instance (PERIOD=4, ON_STEPS=2, TICK_DIV=2, REPEAT=0).
module tb_alarm_pattern_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, stop, snooze;
  logic       light, active, snoozing, done;
  logic [7:0] cycle_count;
  logic       start2, stop2, snooze2;
  logic       light2, active2, snoozing2, done2;
  logic [7:0] cycle_count2;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  alarm_pattern_gen u_dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .snooze(snooze),
    .light(light), .active(active), .snoozing(snoozing), .done(done),
    .cycle_count(cycle_count)
  );

  alarm_pattern_gen #(.PERIOD(4), .ON_STEPS(2), .TICK_DIV(2), .REPEAT(0),
                      .SNOOZE_STEPS(6), .CW(8)) u_dut2 (
    .clock(clock), .reset(reset), .start(start2), .stop(stop2), .snooze(snooze2),
    .light(light2), .active(active2), .snoozing(snoozing2), .done(done2),
    .cycle_count(cycle_count2)
  );

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench in "cycle 0": both DUTs in reset state, inputs idle.
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; stop = 1'b0; snooze = 1'b0;
    start2 = 1'b0; stop2 = 1'b0; snooze2 = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({light, active, snoozing, done, cycle_count} !== 12'h000) begin
      errors++;
      $display("FAIL reset_dut1 got=%b exp=%b", {light, active, snoozing, done, cycle_count}, 12'h000);
    end
    checks++;
    if ({light2, active2, snoozing2, done2, cycle_count2} !== 12'h000) begin
      errors++;
      $display("FAIL reset_dut2 got=%b exp=%b", {light2, active2, snoozing2, done2, cycle_count2}, 12'h000);
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp;
    logic [7:0] exp_cnt;
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      start = 1'b0;
      exp     = {(c == 1 || c == 4 || c == 7 || c == 10), (c <= 12), 1'b0, (c == 13)};
      exp_cnt = (c <= 12) ? 8'((c - 1) / 3) : 8'd4;
      checks++;
      if ({light, active, snoozing, done} !== exp) begin
        errors++;
        $display("FAIL burst_outs cycle=%0d got=%b exp=%b", c, {light, active, snoozing, done}, exp);
      end
      checks++;
      if (cycle_count !== exp_cnt) begin
        errors++;
        $display("FAIL burst_count cycle=%0d got=%0d exp=%0d", c, cycle_count, exp_cnt);
      end
    end
  endtask

  task automatic test_stop();
    logic [3:0] exp;
    logic [7:0] exp_cnt;
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      start = 1'b0;
      stop  = (c == 5);
      exp     = {(c == 1 || c == 4), (c <= 5), 1'b0, 1'b0};
      exp_cnt = (c <= 5) ? 8'((c - 1) / 3) : 8'd1;
      checks++;
      if ({light, active, snoozing, done} !== exp) begin
        errors++;
        $display("FAIL stop_outs cycle=%0d got=%b exp=%b", c, {light, active, snoozing, done}, exp);
      end
      checks++;
      if (cycle_count !== exp_cnt) begin
        errors++;
        $display("FAIL stop_count cycle=%0d got=%0d exp=%0d", c, cycle_count, exp_cnt);
      end
    end
    stop = 1'b0;
  endtask

  // snooze pulsed in cycle 5 and again in cycle re_c (0 = none); RUN resumes in cycle r.
  task automatic test_snooze(input int re_c, input int r);
    logic [3:0] exp;
    logic [7:0] exp_cnt;
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= r + 11; c++) begin
      next_cycle();
      start  = 1'b0;
      snooze = (c == 5) || (c == re_c);
      if (c <= 5) begin
        exp     = {(c == 1 || c == 4), 1'b1, 1'b0, 1'b0};
        exp_cnt = 8'((c - 1) / 3);
      end else if (c < r) begin
        exp     = 4'b0110;
        exp_cnt = 8'd1;
      end else if (c <= r + 8) begin
        exp     = {((c - r) % 3 == 0), 1'b1, 1'b0, 1'b0};
        exp_cnt = 8'(1 + (c - r) / 3);
      end else if (c == r + 9) begin
        exp     = 4'b0001;
        exp_cnt = 8'd4;
      end else begin
        exp     = 4'b0000;
        exp_cnt = 8'd4;
      end
      checks++;
      if ({light, active, snoozing, done} !== exp) begin
        errors++;
        $display("FAIL snooze_outs re=%0d cycle=%0d got=%b exp=%b", re_c, c, {light, active, snoozing, done}, exp);
      end
      checks++;
      if (cycle_count !== exp_cnt) begin
        errors++;
        $display("FAIL snooze_count re=%0d cycle=%0d got=%0d exp=%0d", re_c, c, cycle_count, exp_cnt);
      end
    end
    snooze = 1'b0;
  endtask

  task automatic test_tickdiv();
    logic [3:0] exp;
    logic [7:0] exp_cnt;
    do_reset();
    start2 = 1'b1;
    for (int c = 1; c <= 2062; c++) begin
      next_cycle();
      start2 = 1'b0;
      stop2  = (c == 2060);
      if (c <= 2060) begin
        exp     = {(((c - 1) / 4) % 2 == 0), 1'b1, 1'b0, 1'b0};
        exp_cnt = ((c - 1) / 8 > 255) ? 8'd255 : 8'((c - 1) / 8);
      end else begin
        exp     = 4'b0000;
        exp_cnt = 8'd255;
      end
      if (c <= 40 || c == 2040 || c == 2041 || c >= 2049) begin
        checks++;
        if ({light2, active2, snoozing2, done2} !== exp) begin
          errors++;
          $display("FAIL tickdiv_outs cycle=%0d got=%b exp=%b", c, {light2, active2, snoozing2, done2}, exp);
        end
        checks++;
        if (cycle_count2 !== exp_cnt) begin
          errors++;
          $display("FAIL tickdiv_count cycle=%0d got=%0d exp=%0d", c, cycle_count2, exp_cnt);
        end
      end
    end
    stop2 = 1'b0;
  endtask

  task automatic test_reset_mid_and_conflicts();
    logic [3:0] exp;
    logic [7:0] exp_cnt;
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      start = 1'b0;
      if (c == 7) reset = 1'b1;
      exp     = (c <= 7) ? {(c == 1 || c == 4 || c == 7), 1'b1, 1'b0, 1'b0} : 4'b0000;
      exp_cnt = (c <= 7) ? 8'((c - 1) / 3) : 8'd0;
      checks++;
      if ({light, active, snoozing, done} !== exp) begin
        errors++;
        $display("FAIL rstmid_outs cycle=%0d got=%b exp=%b", c, {light, active, snoozing, done}, exp);
      end
      checks++;
      if (cycle_count !== exp_cnt) begin
        errors++;
        $display("FAIL rstmid_count cycle=%0d got=%0d exp=%0d", c, cycle_count, exp_cnt);
      end
    end
    // start together with reset
    start = 1'b1;
    next_cycle();
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL start_with_reset got=%b exp=0", active);
    end
    reset = 1'b0;
    // start together with stop in IDLE
    stop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      checks++;
      if ({light, active, snoozing, done} !== 4'b0000) begin
        errors++;
        $display("FAIL start_with_stop step=%0d got=%b exp=0000", c, {light, active, snoozing, done});
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    next_cycle();
    checks++;
    if ({active, cycle_count} !== 9'd0) begin
      errors++;
      $display("FAIL conflicts_idle got=%b exp=0", {active, cycle_count});
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_stop();
    test_snooze(0, 12);
    test_snooze(8, 15);
    test_tickdiv();
    test_reset_mid_and_conflicts();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
